// File: rtl/alu_trace_buffer.sv
// Circular trace buffer for ALU issue/result events with optional aluop trigger,
// stop-when-full or wrap-around capture, and a first-word-fall-through drain port.
module alu_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int DEPTH  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cap_valid,
    input  logic [DATA_W-1:0]          cap_a,
    input  logic [DATA_W-1:0]          cap_b,
    input  logic [DATA_W-1:0]          cap_out,
    input  logic [OP_W-1:0]            cap_op,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       trig_en,
    input  logic [OP_W-1:0]            trig_op,
    input  logic                       mode_wrap,
    input  logic                       rd_ready,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_a,
    output logic [DATA_W-1:0]          rd_b,
    output logic [DATA_W-1:0]          rd_out,
    output logic [OP_W-1:0]            rd_op,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [1:0]                 state
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH+1);
    localparam int ENT_W = 3*DATA_W + OP_W;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            overflow_reg, overflow_next;
    logic            mem_we;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;

    logic flush, stop_now, want_wr, full, pop;

    assign flush    = arm && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign stop_now = stop && (state_reg == ST_ARMED || state_reg == ST_CAPTURE);
    assign want_wr  = cap_valid && !stop_now &&
                      (state_reg == ST_CAPTURE ||
                       (state_reg == ST_ARMED && cap_op == trig_op));
    assign full     = (count_reg == CNT_FULL);
    assign pop      = rd_valid && rd_ready;

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        mem_we        = 1'b0;
        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
            state_next    = trig_en ? ST_ARMED : ST_CAPTURE;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
                count_next  = count_reg - CNT_ONE;
            end
            // A full buffer only accepts a write if a pop frees the slot or wrapping is allowed.
            if (want_wr && (!full || pop || mode_wrap)) begin
                mem_we      = 1'b1;
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                if (pop) begin
                    count_next = count_reg;
                end else if (full) begin
                    rd_ptr_next   = rd_ptr_reg + PTR_ONE;
                    overflow_next = 1'b1;
                end else begin
                    count_next = count_reg + CNT_ONE;
                end
                state_next = ST_CAPTURE;
                if (!mode_wrap && count_next == CNT_FULL)
                    state_next = ST_DONE;
            end
            if (stop_now)
                state_next = ST_DONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage carries no reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clock) begin
        if (mem_we)
            mem[wr_ptr_reg] <= {cap_a, cap_b, cap_out, cap_op};
    end

    assign head     = mem[rd_ptr_reg];
    assign rd_valid = (count_reg != '0);
    assign rd_a     = head[ENT_W-1 -: DATA_W];
    assign rd_b     = head[ENT_W-DATA_W-1 -: DATA_W];
    assign rd_out   = head[OP_W +: DATA_W];
    assign rd_op    = head[OP_W-1:0];
    assign count    = count_reg;
    assign overflow = overflow_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_alu_trace_buffer.sv
// Directed self-checking bench for alu_trace_buffer: capture, trigger, full/wrap,
// simultaneous write+pop and asynchronous mid-session reset.
module tb_alu_trace_buffer;
    localparam int DATA_W = 32;
    localparam int OP_W   = 4;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH+1);

    logic              clock = 1'b0;
    logic              reset;
    logic              cap_valid, arm, stop, trig_en, mode_wrap, rd_ready;
    logic [DATA_W-1:0] cap_a, cap_b, cap_out;
    logic [OP_W-1:0]   cap_op, trig_op;
    logic              rd_valid, overflow;
    logic [DATA_W-1:0] rd_a, rd_b, rd_out;
    logic [OP_W-1:0]   rd_op;
    logic [CW-1:0]     count;
    logic [1:0]        state;

    int tests_run = 0;
    int tests_failed = 0;

    alu_trace_buffer #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .cap_valid(cap_valid), .cap_a(cap_a), .cap_b(cap_b), .cap_out(cap_out), .cap_op(cap_op),
        .arm(arm), .stop(stop), .trig_en(trig_en), .trig_op(trig_op), .mode_wrap(mode_wrap),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_a(rd_a), .rd_b(rd_b), .rd_out(rd_out),
        .rd_op(rd_op), .count(count), .overflow(overflow), .state(state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] res, input logic [OP_W-1:0] op);
        cap_valid = 1'b1; cap_a = a; cap_b = b; cap_out = res; cap_op = op;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [DATA_W-1:0] exp_out);
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check({tag, "_out"}, 64'(rd_out), 64'(exp_out));
        rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cap_valid = 0; arm = 0; stop = 0; trig_en = 0; trig_op = '0;
        mode_wrap = 0; rd_ready = 0; cap_a = '0; cap_b = '0; cap_out = '0; cap_op = '0;
        #3;
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // 1: plain capture and ordered drain
        pulse_arm();
        check("t1_state", 64'(state), 64'd2);
        send(7, 8, 15, 2);
        send(7, 8, 15, 0);
        send(7, 8, 15, 0);
        check("t1_count", 64'(count), 64'd3);
        check("t1_a", 64'(rd_a), 64'd7);
        check("t1_b", 64'(rd_b), 64'd8);
        check("t1_op0", 64'(rd_op), 64'd2);
        rd_ready = 1'b1; tick();
        check("t1_op1", 64'(rd_op), 64'd0);
        check("t1_cnt1", 64'(count), 64'd2);
        tick(); tick(); rd_ready = 1'b0;
        check("t1_cnt_end", 64'(count), 64'd0);
        check("t1_valid_end", 64'(rd_valid), 64'd0);
        // event in the same cycle as stop is dropped
        cap_valid = 1'b1; cap_out = 55; stop = 1'b1; tick(); cap_valid = 1'b0; stop = 1'b0;
        check("t1_stop_state", 64'(state), 64'd3);
        check("t1_stop_count", 64'(count), 64'd0);

        // 2: trigger on op 0
        trig_en = 1'b1; trig_op = 4'd0;
        pulse_arm();
        check("t2_armed", 64'(state), 64'd1);
        send(1, 0, 10, 2);
        send(2, 0, 20, 2);
        check("t2_still_armed", 64'(state), 64'd1);
        check("t2_cnt0", 64'(count), 64'd0);
        send(3, 0, 30, 0);
        check("t2_capture", 64'(state), 64'd2);
        send(4, 0, 40, 2);
        check("t2_count", 64'(count), 64'd2);
        check("t2_head_a", 64'(rd_a), 64'd3);
        pop_check("t2_p0", 30);
        pop_check("t2_p1", 40);
        pulse_stop();
        trig_en = 1'b0;

        // 3: stop when full
        mode_wrap = 1'b0;
        pulse_arm();
        for (int i = 0; i < 20; i++) send(100 + i, 0, i, 1);
        check("t3_count", 64'(count), 64'd16);
        check("t3_state", 64'(state), 64'd3);
        check("t3_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) pop_check($sformatf("t3_p%0d", i), i);
        check("t3_empty", 64'(rd_valid), 64'd0);

        // 4: wrap-around overwrite
        mode_wrap = 1'b1;
        pulse_arm();
        for (int i = 0; i < 20; i++) send(0, 0, i, 1);
        check("t4_count", 64'(count), 64'd16);
        check("t4_ovf", 64'(overflow), 64'd1);
        check("t4_state", 64'(state), 64'd2);
        for (int i = 0; i < 16; i++) pop_check($sformatf("t4_p%0d", i), 4 + i);
        check("t4_cnt_end", 64'(count), 64'd0);
        pulse_stop();

        // 5: full, write and pop in the same cycle
        pulse_arm();
        for (int i = 0; i < 16; i++) send(0, 0, i, 1);
        check("t5_full", 64'(count), 64'd16);
        rd_ready = 1'b1; send(0, 0, 99, 1); rd_ready = 1'b0;
        check("t5_count", 64'(count), 64'd16);
        check("t5_ovf", 64'(overflow), 64'd0);
        for (int i = 1; i < 16; i++) pop_check($sformatf("t5_p%0d", i), i);
        pop_check("t5_tail", 99);
        pulse_stop();

        // 6: asynchronous reset between clock edges
        mode_wrap = 1'b0;
        pulse_arm();
        for (int i = 0; i < 5; i++) send(0, 0, i, 1);
        check("t6_pre_count", 64'(count), 64'd5);
        #2 reset = 1'b0;
        #1;
        check("t6_state", 64'(state), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        check("t6_valid", 64'(rd_valid), 64'd0);
        #1 reset = 1'b1;
        tick();
        check("t6_idle_hold", 64'(state), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
